// File: rtl/rtype_exec_wb_if.sv
// rtl/rtype_exec_wb_if.sv - instruction-in / writeback-out handshake bundle for rtype_exec_wb
interface rtype_exec_wb_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [4:0]      alu_control;
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  // Upstream decoder / test driver side
  modport master (
    output in_valid, rs1, rs2, rd, alu_control, wb_ready,
    input  in_ready, wb_valid, wb_rd, wb_data
  );

  // Execute/writeback stage side
  modport slave (
    input  in_valid, rs1, rs2, rd, alu_control, wb_ready,
    output in_ready, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/rtype_exec_wb.sv
// rtl/rtype_exec_wb.sv - R-type execute/writeback stage with regfile, forwarding, loader and retire counter
`ifndef ADD
`define ADD  5'd0
`define SUB  5'd1
`define SLL  5'd2
`define SLT  5'd3
`define SLTU 5'd4
`define XOR  5'd5
`define SRL  5'd6
`define SRA  5'd7
`define OR   5'd8
`define AND  5'd9
`endif

module rtype_exec_wb #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  rtype_exec_wb_if.slave   bus,
  input  logic             ld_en,
  input  logic [4:0]       ld_addr,
  input  logic [XLEN-1:0]  ld_data,
  input  logic [4:0]       dbg_raddr,
  output logic [XLEN-1:0]  dbg_rdata,
  output logic [CNT_W-1:0] retire_count
);

  logic [XLEN-1:0] regs [32];

  logic            wb_valid_q;
  logic [4:0]      wb_rd_q;
  logic [XLEN-1:0] wb_data_q;

  logic            in_ready;
  logic            accept;
  logic            commit;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_result;

  // The WB slot frees up either when empty or when it commits this cycle
  assign in_ready = !wb_valid_q || bus.wb_ready;
  assign accept   = bus.in_valid && in_ready;
  assign commit   = wb_valid_q && bus.wb_ready;

  assign bus.in_ready = in_ready;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;

  // Operand A: x0 is hardwired zero; a pending WB result shadows the regfile
  always_comb begin
    op_a = '0;
    if (bus.rs1 != 5'd0) begin
      if (wb_valid_q && (wb_rd_q == bus.rs1)) begin
        op_a = wb_data_q;
      end else begin
        op_a = regs[bus.rs1];
      end
    end
  end

  // Operand B: same selection as operand A
  always_comb begin
    op_b = '0;
    if (bus.rs2 != 5'd0) begin
      if (wb_valid_q && (wb_rd_q == bus.rs2)) begin
        op_b = wb_data_q;
      end else begin
        op_b = regs[bus.rs2];
      end
    end
  end

  // ALU: shifts use the low five bits of operand B; unknown codes yield zero
  always_comb begin
    alu_result = '0;
    case (bus.alu_control)
      `ADD:  alu_result = op_a + op_b;
      `SUB:  alu_result = op_a - op_b;
      `SLL:  alu_result = op_a << op_b[4:0];
      `SRL:  alu_result = op_a >> op_b[4:0];
      `SRA:  alu_result = $signed(op_a) >>> op_b[4:0];
      `SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      `SLTU: alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      `XOR:  alu_result = op_a ^ op_b;
      `OR:   alu_result = op_a | op_b;
      `AND:  alu_result = op_a & op_b;
      default: alu_result = '0;
    endcase
  end

  // WB slot: load on accept, drain on commit-only, otherwise hold stable
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= '0;
    end else if (accept) begin
      wb_valid_q <= 1'b1;
      wb_rd_q    <= bus.rd;
      wb_data_q  <= alu_result;
    end else if (commit) begin
      wb_valid_q <= 1'b0;
    end
  end

  // Register file: loader write first so a same-index commit overrides it
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (ld_en && (ld_addr != 5'd0)) begin
        regs[ld_addr] <= ld_data;
      end
      if (commit && (wb_rd_q != 5'd0)) begin
        regs[wb_rd_q] <= wb_data_q;
      end
    end
  end

  // Retire counter: every commit counts, including x0 destinations
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_count <= '0;
    end else if (commit) begin
      retire_count <= retire_count + CNT_W'(1);
    end
  end

  assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : regs[dbg_raddr];

endmodule

// File: tb/tb_rtype_exec_wb.sv
// tb/tb_rtype_exec_wb.sv - directed and randomized checks of rtype_exec_wb against a reference model
module tb_rtype_exec_wb;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_SLL  = 5'd2;
  localparam logic [4:0] OP_SLT  = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic [31:0] retire_count;

  rtype_exec_wb_if #(.XLEN(32)) bus ();

  rtype_exec_wb #(.XLEN(32), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .ld_en        (ld_en),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .dbg_raddr    (dbg_raddr),
    .dbg_rdata    (dbg_rdata),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Architectural model: register array, one pending result, retire total
  logic [31:0] m_regs [32];
  logic        m_v;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [31:0] m_cnt;
  logic        m_fresh_reset;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ext;
    int sh;
    sh = int'(b % 32);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SRA: begin
        ext = {{32{a[31]}}, a} >> sh;
        return ext[31:0];
      end
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_XOR:  return a ^ b;
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      default: return 32'd0;
    endcase
  endfunction

  // Latest architectural value of a register, counting a not-yet-committed result
  function automatic logic [31:0] opnd(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (m_v && m_rd == r) return m_data;
    return m_regs[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_v = 1'b0;
    m_rd = 5'd0;
    m_data = 32'd0;
    m_cnt = 32'd0;
    m_fresh_reset = 1'b1;
  endtask

  // One clock: check handshake before the edge, advance the model, check state after it
  task automatic cycle();
    logic acc, com, s_rst, s_ld;
    logic [4:0] s_la;
    logic [31:0] s_ld_data, res;
    #1;
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, (!m_v || bus.wb_ready)});
    acc = bus.in_valid && (!m_v || bus.wb_ready);
    com = m_v && bus.wb_ready;
    res = ref_alu(bus.alu_control, opnd(bus.rs1), opnd(bus.rs2));
    s_rst = rst; s_ld = ld_en; s_la = ld_addr; s_ld_data = ld_data;
    @(posedge clk);
    if (s_rst) begin
      model_reset();
    end else begin
      m_fresh_reset = 1'b0;
      if (s_ld && s_la != 5'd0) m_regs[s_la] = s_ld_data;
      if (com) begin
        if (m_rd != 5'd0) m_regs[m_rd] = m_data;
        m_cnt = m_cnt + 32'd1;
      end
      if (acc) begin
        m_v = 1'b1;
        m_rd = bus.rd;
        m_data = res;
      end else if (com) begin
        m_v = 1'b0;
      end
    end
    #1;
    chk("wb_valid", {31'd0, bus.wb_valid}, {31'd0, m_v});
    chk("retire_count", retire_count, m_cnt);
    if (m_v || m_fresh_reset) begin
      chk("wb_rd", {27'd0, bus.wb_rd}, {27'd0, m_rd});
      chk("wb_data", bus.wb_data, m_data);
    end
    dbg_raddr = 5'($urandom_range(0, 31));
    #1;
    chk("dbg_rdata", dbg_rdata, m_regs[dbg_raddr]);
  endtask

  task automatic issue(input logic [4:0] op, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    bus.in_valid = 1'b1;
    bus.alu_control = op;
    bus.rs1 = a;
    bus.rs2 = b;
    bus.rd = d;
    cycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load(input logic [4:0] a, input logic [31:0] d);
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = d;
    cycle();
    ld_en = 1'b0;
  endtask

  task automatic dbg_expect(input string tag, input logic [4:0] a, input logic [31:0] exp);
    dbg_raddr = a;
    #1;
    chk(tag, dbg_rdata, exp);
  endtask

  initial begin
    rst = 1'b1;
    ld_en = 1'b0; ld_addr = 5'd0; ld_data = 32'd0; dbg_raddr = 5'd0;
    bus.in_valid = 1'b0; bus.wb_ready = 1'b1;
    bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.rd = 5'd0; bus.alu_control = OP_ADD;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset_count", retire_count, 32'd0);

    // 1: simple ADD and commit
    load(5'd1, 32'd5);
    load(5'd2, 32'd3);
    issue(OP_ADD, 5'd1, 5'd2, 5'd3);
    chk("t1_wb_data", bus.wb_data, 32'd8);
    idle(1);
    dbg_expect("t1_x3", 5'd3, 32'd8);
    chk("t1_count", retire_count, 32'd1);

    // 2: back-to-back dependency through forwarding
    issue(OP_SUB, 5'd1, 5'd2, 5'd4);
    issue(OP_ADD, 5'd4, 5'd4, 5'd5);
    chk("t2_fwd", bus.wb_data, 32'd4);
    idle(1);
    dbg_expect("t2_x5", 5'd5, 32'd4);

    // 3: sink stalls for three cycles
    bus.wb_ready = 1'b0;
    issue(OP_XOR, 5'd1, 5'd2, 5'd11);
    bus.in_valid = 1'b1; bus.alu_control = OP_OR; bus.rd = 5'd12;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("t3_hold", bus.wb_data, 32'd6);
      dbg_expect("t3_x11", 5'd11, 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.wb_ready = 1'b1;
    idle(2);
    dbg_expect("t3_x11_after", 5'd11, 32'd6);

    // 4: signed/unsigned shift and compare corners
    load(5'd1, 32'h8000_0000);
    load(5'd2, 32'd4);
    issue(OP_SRA, 5'd1, 5'd2, 5'd6);
    chk("t4_sra", bus.wb_data, 32'hF800_0000);
    issue(OP_SRL, 5'd1, 5'd2, 5'd7);
    chk("t4_srl", bus.wb_data, 32'h0800_0000);
    issue(OP_SLT, 5'd1, 5'd2, 5'd8);
    chk("t4_slt", bus.wb_data, 32'd1);
    issue(OP_SLTU, 5'd1, 5'd2, 5'd9);
    chk("t4_sltu", bus.wb_data, 32'd0);
    idle(1);

    // 5: x0 destination and x0 source
    load(5'd1, 32'd5);
    load(5'd2, 32'd3);
    issue(OP_ADD, 5'd1, 5'd2, 5'd0);
    chk("t5_wb_data", bus.wb_data, 32'd8);
    issue(OP_ADD, 5'd0, 5'd2, 5'd10);
    chk("t5_rs1_zero", bus.wb_data, 32'd3);
    idle(1);
    dbg_expect("t5_x0", 5'd0, 32'd0);

    // Randomized traffic over a small register window to provoke hazards
    for (int r = 1; r < 8; r++) load(5'(r), $urandom);
    for (int i = 0; i < 600; i++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.wb_ready = ($urandom_range(0, 3) != 0);
      bus.alu_control = 5'($urandom_range(0, 11));
      bus.rs1 = 5'($urandom_range(0, 7));
      bus.rs2 = 5'($urandom_range(0, 7));
      bus.rd = 5'($urandom_range(0, 7));
      cycle();
    end
    bus.in_valid = 1'b0;
    bus.wb_ready = 1'b1;
    idle(2);

    // 6: reset while a result is pending
    bus.wb_ready = 1'b0;
    issue(OP_ADD, 5'd1, 5'd2, 5'd13);
    chk("t6_pending", {31'd0, bus.wb_valid}, 32'd1);
    bus.wb_ready = 1'b1;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t6_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("t6_count", retire_count, 32'd0);
    for (int r = 0; r < 32; r++) dbg_expect("t6_reg_zero", 5'(r), 32'd0);
    idle(1);
    dbg_expect("t6_x13", 5'd13, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
